rgb2hsl_seq: RTL and testbench

Parametrised, handshaked successor to the combinational RGB-to-HSL converter. Accepts one pixel of channel width CW per handshake, computes hue in integer degrees and saturation/luminance in 2.FRAC fixed point through a single shared iterative restoring divider, and presents the result on a valid/ready output port. It sits between the pixel source (camera/SDRAM reader) and colour-thresholding logic, trading throughput for exact division at any channel width.

---
 rtl/rgb2hsl_seq.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_rgb2hsl_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2hsl_seq.sv
// rgb2hsl_seq
// -----------------------------------------------------------------------------
// Sequential RGB -> HSL converter. Takes one pixel per input handshake and
// computes three quotients on one shared restoring divider, one after the
// other:
//   lum = floor(sum   * 2^FRAC / (2*MAXV))
//   sat = floor(delta * 2^FRAC / denom)
//   q   = floor(60 * |num| / delta), then hue = base +/- q
// Each quotient takes FRAC+1 cycles and produces one bit per cycle, MSB first.
// The result is held on a valid/ready output port.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset_n    synchronous active-low reset
//   in_valid   R/G/B carry a pixel
//   in_ready   block can take a pixel (high only in IDLE)
//   R, G, B    unsigned CW-bit channels
//   out_valid  hue/sat/lum hold a result (high only in DONE)
//   out_ready  consumer takes the result
//   hue        0..359 degrees
//   sat, lum   2.FRAC fixed point, 0..1.0
//   state_dbg  current FSM state, for observation only
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. Neither ready depends combinationally on the matching
// valid. A result stays valid, with constant data, until it is transferred.
// The block never accepts a new pixel in the same cycle that it hands off a
// result.
// -----------------------------------------------------------------------------
module rgb2hsl_seq #(
  parameter int CW   = 8,
  parameter int FRAC = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   R,
  input  logic [CW-1:0]   G,
  input  logic [CW-1:0]   B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8:0]      hue,
  output logic [FRAC+1:0] sat,
  output logic [FRAC+1:0] lum,
  output logic [2:0]      state_dbg
);

  // The divisor is at most 2*MAXV, which needs CW+1 bits. A trial remainder
  // can reach twice that value, so DW = CW+2. The dividend must hold both
  // sum<<FRAC (CW+1+FRAC bits) and 60*|num| (CW+6 bits).
  localparam int DW   = CW + 2;
  localparam int XW   = CW + FRAC + 6;
  localparam int CNTW = $clog2(FRAC + 1);

  localparam logic [CNTW-1:0] LAST    = CNTW'(FRAC);
  localparam logic [DW-1:0]   TWO_MAX = DW'(2 * ((1 << CW) - 1));
  localparam logic [CW:0]     MAXV_S  = {1'b0, {CW{1'b1}}};
  localparam logic [XW-1:0]   SIXTY   = XW'(60);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    DIV_L = 3'd2,
    DIV_S = 3'd3,
    DIV_H = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Captured pixel.
  logic [CW-1:0]   r_q, g_q, b_q;

  // Per-pixel values, registered in PREP.
  logic [CW-1:0]   delta_q;
  logic [CW:0]     sum_q;
  logic [CW-1:0]   num_abs_q;
  logic            num_neg_q;
  logic [8:0]      base_q;

  // Divider state. quo_q needs only FRAC bits, because the final quotient
  // bit is used directly from quo_nx and never written back.
  logic [DW-1:0]   rem_q;
  logic [FRAC:0]   lo_q;
  logic [FRAC-1:0] quo_q;
  logic [DW-1:0]   dsr_q;
  logic [CNTW-1:0] cnt_q;

  // Results held until the hue quotient is finished.
  logic [FRAC+1:0] lum_q, sat_q;

  // PREP combinational values.
  logic [CW-1:0]   mx_c, mn_c, delta_c, num_abs_c;
  logic [CW:0]     sum_c, num_c;
  logic            num_neg_c;
  logic [8:0]      base_c;

  always_comb begin
    mx_c   = r_q;
    num_c  = {1'b0, g_q} - {1'b0, b_q};
    base_c = 9'd0;
    // Ties favour R over G over B.
    if (r_q >= g_q && r_q >= b_q) begin
      mx_c   = r_q;
      num_c  = {1'b0, g_q} - {1'b0, b_q};
      base_c = 9'd0;
    end else if (g_q >= b_q) begin
      mx_c   = g_q;
      num_c  = {1'b0, b_q} - {1'b0, r_q};
      base_c = 9'd120;
    end else begin
      mx_c   = b_q;
      num_c  = {1'b0, r_q} - {1'b0, g_q};
      base_c = 9'd240;
    end
    mn_c = r_q;
    if (g_q < mn_c) mn_c = g_q;
    if (b_q < mn_c) mn_c = b_q;
    delta_c   = mx_c - mn_c;
    sum_c     = {1'b0, mx_c} + {1'b0, mn_c};
    num_neg_c = num_c[CW];
    num_abs_c = num_neg_c ? CW'((CW+1)'(0) - num_c) : num_c[CW-1:0];
  end

  // One restoring step. Because rem_q < dsr_q always holds, the trial value
  // fits in DW bits and the top bit of rem_q is always zero.
  logic [DW-1:0] trial, rem_nx;
  logic          ge;
  logic [FRAC:0] quo_nx;

  always_comb begin
    trial  = DW'({rem_q, lo_q[FRAC]});
    ge     = (trial >= dsr_q);
    rem_nx = ge ? (trial - dsr_q) : trial;
    quo_nx = {quo_q, ge};
  end

  // Operands for the next division, chosen by the state that is finishing.
  // A quotient fits in FRAC+1 bits whenever dividend < divisor * 2^(FRAC+1).
  // In that case the dividend bits above the low FRAC+1 bits form a value
  // smaller than the divisor, so they can go straight into the remainder.
  logic [XW-1:0] ld_x, ld_sh;
  logic [DW-1:0] ld_d, denom_c;

  always_comb begin
    denom_c = (sum_q <= MAXV_S) ? DW'(sum_q) : (TWO_MAX - DW'(sum_q));
    ld_x = '0;
    ld_d = '0;
    case (state_q)
      PREP: begin
        ld_x = XW'(sum_c) << FRAC;
        ld_d = TWO_MAX;
      end
      DIV_L: begin
        ld_x = XW'(delta_q) << FRAC;
        ld_d = denom_c;
      end
      DIV_S: begin
        ld_x = XW'(num_abs_q) * SIXTY;
        ld_d = DW'(delta_q);
      end
      default: begin
        ld_x = '0;
        ld_d = '0;
      end
    endcase
    ld_sh = ld_x >> (FRAC + 1);
  end

  // Hue from the final quotient, which is at most 60.
  logic [8:0] q9, hue_raw, hue_c;

  always_comb begin
    q9 = {2'b00, quo_nx[6:0]};
    if (!num_neg_q)
      hue_raw = base_q + q9;
    else if (base_q == 9'd0)
      hue_raw = 9'd360 - q9;
    else
      hue_raw = base_q - q9;
    hue_c = (hue_raw == 9'd360) ? 9'd0 : hue_raw;
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid) state_d = PREP;
      PREP:  state_d = DIV_L;
      DIV_L: if (cnt_q == LAST) state_d = (delta_q == '0) ? DONE : DIV_S;
      DIV_S: if (cnt_q == LAST) state_d = DIV_H;
      DIV_H: if (cnt_q == LAST) state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    state_dbg = state_q;
  end

  // Datapath.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      delta_q   <= '0;
      sum_q     <= '0;
      num_abs_q <= '0;
      num_neg_q <= 1'b0;
      base_q    <= '0;
      rem_q     <= '0;
      lo_q      <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      lum_q     <= '0;
      sat_q     <= '0;
      hue       <= '0;
      sat       <= '0;
      lum       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            r_q <= R;
            g_q <= G;
            b_q <= B;
          end
        end
        PREP: begin
          delta_q   <= delta_c;
          sum_q     <= sum_c;
          num_abs_q <= num_abs_c;
          num_neg_q <= num_neg_c;
          base_q    <= base_c;
          rem_q     <= ld_sh[DW-1:0];
          lo_q      <= ld_x[FRAC:0];
          quo_q     <= '0;
          dsr_q     <= ld_d;
          cnt_q     <= '0;
        end
        DIV_L, DIV_S, DIV_H: begin
          if (cnt_q != LAST) begin
            rem_q <= rem_nx;
            lo_q  <= {lo_q[FRAC-1:0], 1'b0};
            quo_q <= quo_nx[FRAC-1:0];
            cnt_q <= cnt_q + CNTW'(1);
          end else begin
            // Last bit: store the quotient and load the next division.
            rem_q <= ld_sh[DW-1:0];
            lo_q  <= ld_x[FRAC:0];
            quo_q <= '0;
            dsr_q <= ld_d;
            cnt_q <= '0;
            if (state_q == DIV_L) begin
              lum_q <= {1'b0, quo_nx};
              // A grey pixel skips the other two divisions.
              if (delta_q == '0) begin
                hue <= '0;
                sat <= '0;
                lum <= {1'b0, quo_nx};
              end
            end else if (state_q == DIV_S) begin
              sat_q <= {1'b0, quo_nx};
            end else begin
              hue <= hue_c;
              sat <= sat_q;
              lum <= lum_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb2hsl_seq.sv
// Testbench for rgb2hsl_seq. Expected results come from a plain-arithmetic
// HSL model, which is itself pinned by hand-computed vectors.
module tb_rgb2hsl_seq;

  localparam int CW   = 8;
  localparam int FRAC = 16;
  localparam int SW   = FRAC + 2;
  localparam int RW   = 9 + 2 * SW;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [CW-1:0] R = '0, G = '0, B = '0;
  logic          in_ready, out_valid;
  logic [8:0]    hue;
  logic [SW-1:0] sat, lum;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] last_res = '0;

  rgb2hsl_seq #(.CW(CW), .FRAC(FRAC)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .R(R), .G(G), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .hue(hue), .sat(sat), .lum(lum),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // HSL model using plain integer arithmetic.
  function automatic logic [RW-1:0] model(input int r, input int g, input int b);
    int mx, mn, d, s, num, base, q, h, den;
    longint sv, lv;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d = mx - mn;
    s = mx + mn;
    if (r == mx)      begin base = 0;   num = g - b; end
    else if (g == mx) begin base = 120; num = b - r; end
    else              begin base = 240; num = r - g; end
    lv = (longint'(s) * (longint'(1) << FRAC)) / (2 * MAXV);
    if (d == 0) begin
      sv = 0;
      h  = 0;
    end else begin
      den = (s <= MAXV) ? s : 2 * MAXV - s;
      sv  = (longint'(d) * (longint'(1) << FRAC)) / den;
      q   = (60 * ((num < 0) ? -num : num)) / d;
      h   = (num < 0) ? base - q : base + q;
      if (h < 0) h += 360;
      if (h >= 360) h -= 360;
    end
    return {h[8:0], sv[SW-1:0], lv[SW-1:0]};
  endfunction

  function automatic int exp_latency(input int r, input int g, input int b);
    int mx, mn;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    return (mx == mn) ? (FRAC + 1) + 2 : 3 * (FRAC + 1) + 2;
  endfunction

  // ---------------- driver ----------------
  // Call this 2 time units after a rising edge. The task returns 2 time
  // units after the accept edge when push=0. When push=1 it returns once
  // out_valid is high. Latency counts the accept edge as cycle 1.
  task automatic send_pixel(input int r, input int g, input int b, input bit push);
    int n;
    int lat;
    bit busy_ok;
    R = CW'(r); G = CW'(g); B = CW'(b);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #2; n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk);  // accept edge
    #2;
    in_valid = 1'b0;
    R = CW'($urandom_range(0, MAXV));
    G = CW'($urandom_range(0, MAXV));
    B = CW'($urandom_range(0, MAXV));
    if (push) begin
      exp_q.push_back(model(r, g, b));
      lat = 1;
      busy_ok = 1'b1;
      while (!out_valid && lat < 300) begin
        if (in_ready) busy_ok = 1'b0;
        @(posedge clk); #2; lat++;
      end
      if (in_ready) busy_ok = 1'b0;
      check("latency", RW'(lat), RW'(exp_latency(r, g, b)));
      check("in_ready_busy", RW'(busy_ok), RW'(1));
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      last_res = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_result: out_valid=1 with nothing pending, got 0x%0h", {hue, sat, lum});
      end else begin
        check("result", {hue, sat, lum}, exp_q[0]);
        if (out_ready) last_res = exp_q.pop_front();
      end
    end else begin
      check("hold", {hue, sat, lum}, last_res);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    int r, g, b, h, s, l;
  } vec_t;

  vec_t vecs[11] = '{
    '{255, 255, 255,   0,     0, 65536},
    '{  0,   0,   0,   0,     0,     0},
    '{255,   0,   0,   0, 65536, 32768},
    '{  0, 255,   0, 120, 65536, 32768},
    '{  0,   0, 255, 240, 65536, 32768},
    '{128,  64,  32,  20, 39321, 20560},
    '{255, 200, 200,   0, 65536, 58468},
    '{255,   0, 255, 300, 65536, 32768},
    '{255,   0,   1,   0, 65536, 32768},
    '{ 10,  20,  30, 210, 32768,  5140},
    '{200, 100, 150, 330, 31207, 38550}
  };

  initial begin
    logic [RW-1:0] pin;
    bit no_valid;

    // reset
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #2;
    check("reset_in_ready", RW'(in_ready), RW'(1));
    check("reset_out_valid", RW'(out_valid), RW'(0));
    check("reset_outputs", {hue, sat, lum}, '0);

    // directed table: pin the model, then run through the DUT
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      pin = {9'(vecs[i].h), SW'(vecs[i].s), SW'(vecs[i].l)};
      check("model_pin", model(vecs[i].r, vecs[i].g, vecs[i].b), pin);
      send_pixel(vecs[i].r, vecs[i].g, vecs[i].b, 1'b1);
    end

    // a few random pixels, checked against the model
    for (int i = 0; i < 4; i++)
      send_pixel($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, MAXV), 1'b1);

    // back-pressure
    @(posedge clk); #2;
    out_ready = 1'b0;
    send_pixel(128, 64, 32, 1'b1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      R = CW'($urandom_range(0, MAXV));
      G = CW'($urandom_range(0, MAXV));
      B = CW'($urandom_range(0, MAXV));
      @(posedge clk); #2;
      check("bp_in_ready", RW'(in_ready), RW'(0));
      check("bp_out_valid", RW'(out_valid), RW'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    check("bp_release_in_ready", RW'(in_ready), RW'(1));
    check("bp_release_out_valid", RW'(out_valid), RW'(0));

    // reset in the middle of the saturation division
    send_pixel(200, 100, 150, 1'b0);
    repeat (25) @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    no_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (out_valid) no_valid = 1'b0;
    end
    check("abort_no_valid", RW'(no_valid), RW'(1));
    check("abort_outputs_zero", {hue, sat, lum}, '0);
    check("abort_in_ready", RW'(in_ready), RW'(1));

    send_pixel(255, 0, 0, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", RW'(exp_q.size()), RW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
